// File: rtl/sort_n_floats_seq_pkg.sv
// Shared definitions for the batch float sorter: float width, FSM states, counter sizing.
// Pure declarations, no logic; imported by every file of the block.
package sort_n_floats_seq_pkg;

    localparam int FLEN = 32;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/f_less_or_equal.sv
// IEEE-754 a <= b comparator; err flags a NaN operand (res is then 0).
// Latency: combinational. Backpressure: none.
module f_less_or_equal
    import sort_n_floats_seq_pkg::*;
(
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            res,
    output logic            err
);

    localparam int EW = (FLEN == 64) ? 11 : (FLEN == 16) ? 5 : 8;
    localparam int MW = FLEN - 1 - EW;

    logic [FLEN-2:0] a_mag;
    logic [FLEN-2:0] b_mag;
    logic            a_nan;
    logic            b_nan;

    assign a_mag = a[FLEN-2:0];
    assign b_mag = b[FLEN-2:0];
    assign a_nan = (&a[FLEN-2:MW]) && (|a[MW-1:0]);
    assign b_nan = (&b[FLEN-2:MW]) && (|b[MW-1:0]);
    assign err   = a_nan || b_nan;

    // +0 and -0 compare equal, so neither order causes a swap.
    always_comb begin
        res = 1'b0;
        if (err) begin
            res = 1'b0;
        end else if (a_mag == '0 && b_mag == '0) begin
            res = 1'b1;
        end else begin
            case ({a[FLEN-1], b[FLEN-1]})
                2'b10:   res = 1'b1;
                2'b01:   res = 1'b0;
                2'b00:   res = (a_mag <= b_mag);
                default: res = (a_mag >= b_mag);
            endcase
        end
    end

endmodule

// File: rtl/sort_n_floats_seq_float_cmp_swap.sv
// Compare-exchange cell: lo/hi ordered output of a pair, swaps only when a > b and no NaN.
// Latency: combinational. Backpressure: none.
module float_cmp_swap
    import sort_n_floats_seq_pkg::*;
(
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic [FLEN-1:0] lo,
    output logic [FLEN-1:0] hi,
    output logic            swapped,
    output logic            err
);

    logic le;

    f_less_or_equal u_cmp (
        .a   (a),
        .b   (b),
        .res (le),
        .err (err)
    );

    assign swapped = !le && !err;
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/sort_n_floats_seq.sv
// Batch sorter: loads N floats, odd-even transposition sort, streams them out smallest first.
// Latency: N+1 cycles last-in to first-out (SORT_FLOATS_EARLY_EXIT_EN may shorten SORT).
// Backpressure: up_ready only in LOAD; OUT holds all outputs while down_ready is low.
module sort_n_floats_seq
    import sort_n_floats_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    output logic            up_ready,
    input  logic [FLEN-1:0] up_data,
    output logic            down_valid,
    input  logic            down_ready,
    output logic [FLEN-1:0] down_data,
    output logic            down_last,
    output logic            down_err
);

    localparam int            CW   = cnt_width(N);
    localparam int            HALF = N / 2;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   phase_q, phase_d;
    logic            err_q, err_d;
    logic [FLEN-1:0] buf_q [N];
    logic [FLEN-1:0] buf_d [N];
`ifdef SORT_FLOATS_EARLY_EXIT_EN
    logic            quiet_q, quiet_d;
`endif

    logic [FLEN-1:0] even_res [N];
    logic [FLEN-1:0] odd_res  [N];
    logic [FLEN-1:0] cell_a  [HALF];
    logic [FLEN-1:0] cell_b  [HALF];
    logic [FLEN-1:0] cell_lo [HALF];
    logic [FLEN-1:0] cell_hi [HALF];
    logic [HALF-1:0] cell_en;
    logic [HALF-1:0] cell_sw;
    logic [HALF-1:0] cell_err;
    logic            any_sw;
    logic            any_err;
    logic            sort_done;

    // Each cell serves pair (2k,2k+1) in even phases and (2k+1,2k+2) in odd phases.
    for (genvar k = 0; k < HALF; k++) begin : g_cell
        if (2 * k + 2 < N) begin : g_both
            assign cell_a[k]      = phase_q[0] ? buf_q[2*k+1] : buf_q[2*k];
            assign cell_b[k]      = phase_q[0] ? buf_q[2*k+2] : buf_q[2*k+1];
            assign cell_en[k]     = 1'b1;
            assign odd_res[2*k+1] = cell_lo[k];
            assign odd_res[2*k+2] = cell_hi[k];
        end else begin : g_even_only
            assign cell_a[k]  = buf_q[2*k];
            assign cell_b[k]  = buf_q[2*k+1];
            assign cell_en[k] = !phase_q[0];
        end
        assign even_res[2*k]   = cell_lo[k];
        assign even_res[2*k+1] = cell_hi[k];

        float_cmp_swap u_cell (
            .a       (cell_a[k]),
            .b       (cell_b[k]),
            .lo      (cell_lo[k]),
            .hi      (cell_hi[k]),
            .swapped (cell_sw[k]),
            .err     (cell_err[k])
        );
    end

    assign odd_res[0] = buf_q[0];
    if (N % 2 == 0) begin : g_odd_tail
        assign odd_res[N-1] = buf_q[N-1];
    end else begin : g_even_tail
        assign even_res[N-1] = buf_q[N-1];
    end

    assign any_sw  = |(cell_sw & cell_en);
    assign any_err = |(cell_err & cell_en);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        err_d      = err_q;
        buf_d      = buf_q;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
        quiet_d    = quiet_q;
`endif
        sort_done  = 1'b0;
        up_ready   = 1'b0;
        down_valid = 1'b0;
        down_data  = '0;
        down_last  = 1'b0;
        down_err   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                up_ready = 1'b1;
                if (up_valid) begin
                    buf_d[cnt_q] = up_data;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        phase_d = '0;
                        err_d   = 1'b0;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
                        quiet_d = 1'b0;
`endif
                        state_d = ST_SORT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            ST_SORT: begin
                for (int i = 0; i < N; i++) begin
                    buf_d[i] = phase_q[0] ? odd_res[i] : even_res[i];
                end
                err_d     = err_q || any_err;
                phase_d   = phase_q + CW'(1);
                sort_done = (phase_q == LAST);
`ifdef SORT_FLOATS_EARLY_EXIT_EN
                // Two consecutive swap-free phases cover every adjacent pair: sorted.
                quiet_d = !any_sw;
                if (!any_sw && quiet_q) begin
                    sort_done = 1'b1;
                end
`endif
                if (sort_done) begin
                    phase_d = '0;
                    cnt_d   = '0;
                    state_d = ST_OUT;
                end
            end

            ST_OUT: begin
                down_valid = 1'b1;
                down_data  = buf_q[cnt_q];
                down_last  = (cnt_q == LAST);
                down_err   = err_q;
                if (down_ready) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            phase_q <= '0;
            err_q   <= 1'b0;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
            quiet_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            err_q   <= err_d;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
            quiet_q <= quiet_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_sort_n_floats_seq.sv
// Bench for sort_n_floats_seq: N=4 and N=8 instances, vector table, corner sequences, random batches.
module tb_sort_n_floats_seq;

    typedef logic [7:0][31:0] arr_t;
    typedef struct packed {
        logic       s;
        logic [3:0] n;
        arr_t       vin;
        arr_t       vexp;
    } vec_t;

`ifdef SORT_FLOATS_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        up_valid;
    logic        down_ready;
    logic [31:0] up_data;

    logic        u4_up_valid, u4_up_ready, u4_down_valid, u4_down_ready, u4_down_last, u4_down_err;
    logic        u8_up_valid, u8_up_ready, u8_down_valid, u8_down_ready, u8_down_last, u8_down_err;
    logic [31:0] u4_down_data, u8_down_data;

    assign u4_up_valid   = up_valid & ~sel;
    assign u8_up_valid   = up_valid & sel;
    assign u4_down_ready = down_ready & ~sel;
    assign u8_down_ready = down_ready & sel;

    logic        m_up_ready, m_down_valid, m_down_last, m_down_err;
    logic [31:0] m_down_data;
    assign m_up_ready   = sel ? u8_up_ready   : u4_up_ready;
    assign m_down_valid = sel ? u8_down_valid : u4_down_valid;
    assign m_down_last  = sel ? u8_down_last  : u4_down_last;
    assign m_down_err   = sel ? u8_down_err   : u4_down_err;
    assign m_down_data  = sel ? u8_down_data  : u4_down_data;

    sort_n_floats_seq #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .up_valid(u4_up_valid), .up_ready(u4_up_ready), .up_data(up_data),
        .down_valid(u4_down_valid), .down_ready(u4_down_ready), .down_data(u4_down_data),
        .down_last(u4_down_last), .down_err(u4_down_err)
    );

    sort_n_floats_seq #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .up_valid(u8_up_valid), .up_ready(u8_up_ready), .up_data(up_data),
        .down_valid(u8_down_valid), .down_ready(u8_down_ready), .down_data(u8_down_data),
        .down_last(u8_down_last), .down_err(u8_down_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic arr_t mk8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        arr_t r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    // Real-number ordering key: signed magnitude, so -0 and +0 share key 0.
    function automatic longint key(input logic [31:0] x);
        longint m;
        m = longint'({33'b0, x[30:0]});
        return x[31] ? -m : m;
    endfunction

    // Stable reference: repeatedly take the first occurrence of the smallest key.
    function automatic arr_t ref_sort(input arr_t v, input int n);
        logic [31:0] q[$];
        arr_t        r;
        int          j;
        r = '0;
        for (int i = 0; i < n; i++) q.push_back(v[i]);
        for (int o = 0; o < n; o++) begin
            j = 0;
            for (int i = 1; i < q.size(); i++) begin
                if (key(q[i]) < key(q[j])) j = i;
            end
            r[o] = q[j];
            q.delete(j);
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = 32'h0000_0000;
            1: r = 32'h8000_0000;
            2: r = 32'h3F80_0000;
            3: r = 32'hBF80_0000;
            default: begin
                r = $urandom;
                if (r[30:23] == 8'hFF) r[22:0] = '0;
            end
        endcase
        return r;
    endfunction

    task automatic send_beats(input int n, input arr_t vin);
        int g;
        for (int b = 0; b < n; b++) begin
            up_valid = 1'b1;
            up_data  = vin[b];
            g = 0;
            while (!m_up_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) chk1($sformatf("up_ready timeout beat %0d", b), 1'b0, 1'b1);
            @(negedge clk);
        end
        up_valid = 1'b0;
        up_data  = '0;
    endtask

    task automatic run_batch(input bit s, input int n, input arr_t vin, input arr_t vexp,
                             input logic xerr, input bit chk_data, input int xlat,
                             input int stall_at, input bit rnd_rdy);
        int lat, i, g, stalls;
        bit rdy;
        sel        = s;
        down_ready = 1'b0;
        send_beats(n, vin);
        lat = 1;
        while (!m_down_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk1("first down_valid", m_down_valid, 1'b1);
        if (xlat != 0) chk("latency", 32'(lat), 32'(xlat));
        i = 0; g = 0; stalls = 0;
        while (i < n && g < 1000) begin
            rdy = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (i == stall_at && stalls < 5) begin
                rdy = 1'b0;
                stalls++;
            end
            down_ready = rdy;
            chk1($sformatf("beat %0d valid", i), m_down_valid, 1'b1);
            if (chk_data) chk($sformatf("beat %0d data", i), m_down_data, vexp[i]);
            chk1($sformatf("beat %0d last", i), m_down_last, (i == n - 1));
            chk1($sformatf("beat %0d err", i), m_down_err, xerr);
            chk1($sformatf("beat %0d up_ready low in OUT", i), m_up_ready, 1'b0);
            if (rdy) i++;
            g++;
            @(negedge clk);
        end
        if (i < n) chk("output beat count", 32'(i), 32'(n));
        down_ready = 1'b0;
        chk1("up_ready after batch", m_up_ready, 1'b1);
        chk1("down_valid after batch", m_down_valid, 1'b0);
    endtask

    vec_t tbl[4];
    arr_t rin, rexp, sorted8;

    initial begin
        tbl[0] = '{s: 1'b0, n: 4'd4,
                   vin:  mk8(32'h40400000, 32'h3F800000, 32'h40000000, 32'hBF800000, 0, 0, 0, 0),
                   vexp: mk8(32'hBF800000, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, 0)};
        tbl[1] = '{s: 1'b0, n: 4'd4,
                   vin:  mk8(32'h80000000, 32'h00000000, 32'h3F800000, 32'hBF800000, 0, 0, 0, 0),
                   vexp: mk8(32'hBF800000, 32'h80000000, 32'h00000000, 32'h3F800000, 0, 0, 0, 0)};
        tbl[2] = '{s: 1'b0, n: 4'd4,
                   vin:  mk8(32'h7F800000, 32'hFF800000, 32'h00000000, 32'h3F800000, 0, 0, 0, 0),
                   vexp: mk8(32'hFF800000, 32'h00000000, 32'h3F800000, 32'h7F800000, 0, 0, 0, 0)};
        tbl[3] = '{s: 1'b1, n: 4'd8,
                   vin:  mk8(32'h40A00000, 32'h40400000, 32'h40400000, 32'h00000000,
                             32'h80000000, 32'hBF800000, 32'hC0000000, 32'hC0000000),
                   vexp: mk8(32'hC0000000, 32'hC0000000, 32'hBF800000, 32'h00000000,
                             32'h80000000, 32'h40400000, 32'h40400000, 32'h40A00000)};
        sorted8 = mk8(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                      32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000);

        rst = 1'b1; sel = 1'b0; up_valid = 1'b0; down_ready = 1'b0; up_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk1("rst u4 up_ready", u4_up_ready, 1'b1);
        chk1("rst u4 down_valid", u4_down_valid, 1'b0);
        chk1("rst u4 down_last", u4_down_last, 1'b0);
        chk1("rst u4 down_err", u4_down_err, 1'b0);
        chk("rst u4 down_data", u4_down_data, 32'h0);
        chk1("rst u8 up_ready", u8_up_ready, 1'b1);
        chk1("rst u8 down_valid", u8_down_valid, 1'b0);
        chk("rst u8 down_data", u8_down_data, 32'h0);

        // NaN batch: err on every beat, then the next batch must start clean.
        run_batch(1'b0, 4, mk8(32'h3F800000, 32'h7FC00000, 32'h40000000, 32'h00000000, 0, 0, 0, 0),
                  '0, 1'b1, 1'b0, EE ? 0 : 5, -1, 1'b0);

        for (int t = 0; t < 4; t++) begin
            run_batch(tbl[t].s, int'(tbl[t].n), tbl[t].vin, tbl[t].vexp, 1'b0, 1'b1,
                      EE ? 0 : int'(tbl[t].n) + 1, -1, 1'b0);
        end

        // Five-cycle stall on the third output beat.
        run_batch(1'b0, 4, tbl[0].vin, tbl[0].vexp, 1'b0, 1'b1, 0, 2, 1'b0);

        run_batch(1'b1, 8, sorted8, sorted8, 1'b0, 1'b1, EE ? 3 : 9, -1, 1'b0);

        // Reset while sorting, then a fresh batch.
        sel = 1'b0;
        send_beats(4, mk8(32'h41100000, 32'h41000000, 32'h40E00000, 32'h40C00000, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("abort up_ready", m_up_ready, 1'b1);
        chk1("abort down_valid", m_down_valid, 1'b0);
        run_batch(1'b0, 4, mk8(32'h3F000000, 32'hC0000000, 32'h40800000, 32'h3F800000, 0, 0, 0, 0),
                  mk8(32'hC0000000, 32'h3F000000, 32'h3F800000, 32'h40800000, 0, 0, 0, 0),
                  1'b0, 1'b1, EE ? 0 : 5, -1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            run_batch(1'b1, 8, tbl[3].vin, tbl[3].vexp, 1'b0, 1'b1, EE ? 0 : 9, -1, 1'b0);
        end

        for (int r = 0; r < 24; r++) begin
            int n;
            n = (r % 2 == 1) ? 8 : 4;
            rin = '0;
            for (int i = 0; i < n; i++) rin[i] = rnd_f();
            rexp = ref_sort(rin, n);
            run_batch(r % 2 == 1, n, rin, rexp, 1'b0, 1'b1, EE ? 0 : n + 1, -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
